fetch_pack_unit: RTL and testbench

//  Parametrised successor to the two-lane fetch data controller.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/lane_compactor.sv | 29 ++
 rtl/fetch_pack_unit.sv | 123 ++++++++++++
 tb/tb_fetch_pack_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch pack unit: state encodings and width helpers.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_FULL    = 2'b10
    } fetch_state_e;

    // Pointer width for a power-of-two buffer depth (at least one bit).
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lane_compactor.sv
// Combinational prefix-sum over the keep mask of a fetch group: each lane gets
// the slot offset it lands at after bubbles are squeezed out, plus the total.
module lane_compactor
    import fetch_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned NW    = cnt_w(LANES)
) (
    input  logic [LANES-1:0]         in_zero,
    output logic [LANES-1:0][NW-1:0] offset,
    output logic [NW-1:0]            n_push
);

    logic [NW-1:0] acc;

    // Running count of kept lanes below each lane index.
    always_comb begin
        acc    = '0;
        offset = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            offset[i] = acc;
            if (!in_zero[i]) begin
                acc = acc + NW'(1);
            end
        end
        n_push = acc;
    end

endmodule

// File: rtl/fetch_pack_unit.sv
// Fetch pack unit: drops bubble lanes of each fetch group, packs the remaining
// words in lane order into a circular buffer and presents up to LANES oldest
// words per cycle to decode.
module fetch_pack_unit
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       preset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [LANES*WIDTH-1:0]     in_data,
    input  logic [LANES-1:0]           in_zero,
    output logic                       in_ready,
    output logic [LANES-1:0]           out_valid,
    output logic [LANES*WIDTH-1:0]     out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [1:0]                 state
);

    localparam int unsigned PW        = ptr_w(DEPTH);
    localparam int unsigned CW        = cnt_w(DEPTH);
    localparam int unsigned NW        = cnt_w(LANES);
    localparam int unsigned READY_MAX = DEPTH - LANES;
    localparam logic [CW-1:0] LANES_C = CW'(LANES);

    logic [WIDTH-1:0]        mem_q [DEPTH];
    logic [PW-1:0]           rd_ptr_q;
    logic [PW-1:0]           wr_ptr_q;
    logic [CW-1:0]           count_q;
    fetch_state_e            state_q;

    logic [LANES-1:0][NW-1:0] offset;
    logic [NW-1:0]            n_push;
    logic                     push;
    logic [CW-1:0]            n_push_c;
    logic [CW-1:0]            n_pop_c;
    logic [CW-1:0]            count_d;
    fetch_state_e             state_d;

    lane_compactor #(
        .LANES (LANES),
        .NW    (NW)
    ) u_compactor (
        .in_zero (in_zero),
        .offset  (offset),
        .n_push  (n_push)
    );

    // Acceptance depends only on registered occupancy; a pop this cycle does not help.
    assign in_ready = (32'(count_q) <= READY_MAX);
    assign push     = in_valid & in_ready;
    assign count    = count_q;
    assign state    = state_q;

    // Next occupancy and next state; flush forces the buffer empty.
    always_comb begin
        n_push_c = push ? CW'(n_push) : '0;
        n_pop_c  = '0;
        if (out_ready) begin
            n_pop_c = (count_q < LANES_C) ? count_q : LANES_C;
        end
        count_d = count_q + n_push_c - n_pop_c;
        if (flush) begin
            count_d = '0;
        end
        if (count_d == '0) begin
            state_d = ST_EMPTY;
        end else if (32'(count_d) > READY_MAX) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_PARTIAL;
        end
    end

    // Pointer, occupancy and state registers.
    always_ff @(posedge clk) begin
        if (preset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_EMPTY;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_EMPTY;
        end else begin
            rd_ptr_q <= rd_ptr_q + PW'(n_pop_c);
            wr_ptr_q <= wr_ptr_q + PW'(n_push_c);
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

    // Buffer storage: kept lanes land at consecutive slots from wr_ptr; no reset.
    always_ff @(posedge clk) begin
        if (!preset && !flush && push) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (!in_zero[i]) begin
                    mem_q[wr_ptr_q + PW'(offset[i])] <= in_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Output mux: oldest word in lane 0, unoccupied lanes driven to zero.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (32'(count_q) > i) begin
                out_valid[i]                = 1'b1;
                out_data[i*WIDTH +: WIDTH]  = mem_q[rd_ptr_q + PW'(i)];
            end
        end
    end

endmodule

// File: tb/tb_fetch_pack_unit.sv
// Directed bench for fetch_pack_unit: a 2-lane/4-deep instance for the main
// sequence and a 4-lane/8-deep instance for the wider packing case.
module tb_fetch_pack_unit;

    logic        clk = 1'b0;
    logic        preset, flush, in_valid, out_ready;
    logic [63:0] in_data;
    logic [1:0]  in_zero;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_data;
    logic [2:0]  count;
    logic [1:0]  state;

    logic         flush4, in_valid4, out_ready4;
    logic [127:0] in_data4;
    logic [3:0]   in_zero4;
    logic         in_ready4;
    logic [3:0]   out_valid4;
    logic [127:0] out_data4;
    logic [3:0]   count4;
    logic [1:0]   state4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_pack_unit #(.WIDTH(32), .LANES(2), .DEPTH(4)) u_dut (
        .clk(clk), .preset(preset), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .in_zero(in_zero), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count), .state(state)
    );

    fetch_pack_unit #(.WIDTH(32), .LANES(4), .DEPTH(8)) u_dut4 (
        .clk(clk), .preset(preset), .flush(flush4), .in_valid(in_valid4),
        .in_data(in_data4), .in_zero(in_zero4), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready4),
        .count(count4), .state(state4)
    );

    // Bubble flags must be known whenever a group is offered.
    always @(posedge clk) begin
        if (in_valid === 1'b1) assert (!$isunknown(in_zero)) else $error("in_zero unknown");
        if (in_valid4 === 1'b1) assert (!$isunknown(in_zero4)) else $error("in_zero4 unknown");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        preset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_data = {32'h11111111, 32'h22222222}; in_zero = 2'b00;
        flush4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0;
        in_data4 = '0; in_zero4 = '0;

        // 1. reset with in_valid high
        tick(); tick();
        check_eq("rst_out_valid", 128'(out_valid), 128'(2'b00));
        check_eq("rst_count", 128'(count), 128'(3'd0));
        check_eq("rst_state", 128'(state), 128'(2'b00));
        check_eq("rst_in_ready", 128'(in_ready), 128'(1'b1));
        check_eq("rst_count4", 128'(count4), 128'(4'd0));
        preset = 1'b0; in_valid = 1'b0;
        tick();
        check_eq("rst_nothing_stored", 128'(count), 128'(3'd0));

        // all-bubble group is accepted but stores nothing
        in_valid = 1'b1; in_zero = 2'b11;
        tick();
        in_valid = 1'b0;
        check_eq("allzero_count", 128'(count), 128'(3'd0));
        check_eq("allzero_valid", 128'(out_valid), 128'(2'b00));

        // 2. full group push
        in_valid = 1'b1; in_zero = 2'b00; in_data = {32'hB0000002, 32'hA0000001};
        tick();
        in_valid = 1'b0;
        check_eq("push2_valid", 128'(out_valid), 128'(2'b11));
        check_eq("push2_data", 128'(out_data), 128'({32'hB0000002, 32'hA0000001}));
        check_eq("push2_count", 128'(count), 128'(3'd2));
        check_eq("push2_state", 128'(state), 128'(2'b01));

        // 3. lane0 bubble, lane1 kept
        in_valid = 1'b1; in_zero = 2'b01; in_data = {32'hC0000003, 32'hDEADBEEF};
        tick();
        in_valid = 1'b0;
        check_eq("push1_count", 128'(count), 128'(3'd3));
        check_eq("push1_state", 128'(state), 128'(2'b10));
        check_eq("push1_in_ready", 128'(in_ready), 128'(1'b0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("pop2_valid", 128'(out_valid), 128'(2'b01));
        check_eq("pop2_data", 128'(out_data), 128'({32'h0, 32'hC0000003}));
        check_eq("pop2_count", 128'(count), 128'(3'd1));

        // 4. fill to 4 (rd=2): one word then two
        in_valid = 1'b1; in_zero = 2'b10; in_data = {32'h12345678, 32'hD0000004};
        tick();
        in_zero = 2'b00; in_data = {32'hF0000006, 32'hE0000005};
        tick();
        check_eq("fill_count", 128'(count), 128'(3'd4));
        check_eq("fill_state", 128'(state), 128'(2'b10));
        in_data = {32'h22222222, 32'h11111111};
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_count", 128'(count), 128'(3'd4));
            check_eq("hold_in_ready", 128'(in_ready), 128'(1'b0));
            check_eq("hold_data", 128'(out_data), 128'({32'hD0000004, 32'hC0000003}));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        check_eq("drain_count", 128'(count), 128'(3'd2));
        check_eq("drain_in_ready", 128'(in_ready), 128'(1'b1));
        check_eq("drain_data", 128'(out_data), 128'({32'hF0000006, 32'hE0000005}));
        check_eq("drain_state", 128'(state), 128'(2'b01));

        // 5. walk rd_ptr to 3, then push+pop across the wrap
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("empty_count", 128'(count), 128'(3'd0));
        check_eq("empty_state", 128'(state), 128'(2'b00));
        in_valid = 1'b1; in_zero = 2'b10; in_data = {32'h0BADF00D, 32'h77770007};
        tick();
        check_eq("g_data", 128'(out_data), 128'({32'h0, 32'h77770007}));
        in_zero = 2'b00; in_data = {32'h99990009, 32'h88880008}; out_ready = 1'b1;
        tick();
        check_eq("wrap_count", 128'(count), 128'(3'd2));
        check_eq("wrap_data", 128'(out_data), 128'({32'h99990009, 32'h88880008}));
        in_data = {32'hBBBB000B, 32'hAAAA000A};
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check_eq("pushpop_count", 128'(count), 128'(3'd2));
        check_eq("pushpop_data", 128'(out_data), 128'({32'hBBBB000B, 32'hAAAA000A}));
        check_eq("pushpop_state", 128'(state), 128'(2'b01));

        // 6. flush at count=3 with push and pop requested
        in_valid = 1'b1; in_zero = 2'b01; in_data = {32'hCCCC000C, 32'h0};
        tick();
        check_eq("pre_flush_count", 128'(count), 128'(3'd3));
        flush = 1'b1; out_ready = 1'b1; in_zero = 2'b00; in_data = {32'h12121212, 32'h34343434};
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check_eq("flush_count", 128'(count), 128'(3'd0));
        check_eq("flush_valid", 128'(out_valid), 128'(2'b00));
        check_eq("flush_state", 128'(state), 128'(2'b00));
        in_valid = 1'b1; in_data = {32'hEEEE000E, 32'hDDDD000D};
        tick();
        in_valid = 1'b0;
        check_eq("post_flush_data", 128'(out_data), 128'({32'hEEEE000E, 32'hDDDD000D}));
        preset = 1'b1; flush = 1'b1; in_valid = 1'b1;
        tick();
        preset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        check_eq("rstflush_count", 128'(count), 128'(3'd0));
        check_eq("rstflush_state", 128'(state), 128'(2'b00));
        check_eq("rstflush_in_ready", 128'(in_ready), 128'(1'b1));

        // LANES=4, DEPTH=8: lanes 0 and 2 kept
        in_valid4 = 1'b1; in_zero4 = 4'b1010;
        in_data4 = {32'h40000000, 32'h30000000, 32'h20000000, 32'h10000000};
        tick();
        check_eq("l4_valid", 128'(out_valid4), 128'(4'b0011));
        check_eq("l4_data", out_data4, {64'h0, 32'h30000000, 32'h10000000});
        check_eq("l4_state", 128'(state4), 128'(2'b01));
        in_zero4 = 4'b0000;
        in_data4 = {32'h41000000, 32'h31000000, 32'h21000000, 32'h11000000};
        tick();
        in_valid4 = 1'b0;
        check_eq("l4_count", 128'(count4), 128'(4'd6));
        check_eq("l4_full", 128'(state4), 128'(2'b10));
        check_eq("l4_in_ready", 128'(in_ready4), 128'(1'b0));
        check_eq("l4_data2", out_data4,
                 {32'h21000000, 32'h11000000, 32'h30000000, 32'h10000000});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
